// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared RAM status, arbiter state and word types for the multi-core RAM arbiter
package memory_arbiter_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, SERVE} arb_state_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: CPU I/D request channels plus RAM port; master = CPUs/RAM side, slave = arbiter
interface memory_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]        iwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] dload;
  logic [ADDR_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic                   ramREN;
  logic                   ramWEN;
  ramstate_t              ramstate;
  logic [WORD_W-1:0]      ramload;
  logic                   timeout_err;
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  iwait, iload, dwait, dload, ramaddr, ramstore, ramREN, ramWEN, timeout_err
  );
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, iload, dwait, dload, ramaddr, ramstore, ramREN, ramWEN, timeout_err
  );
endinterface

// File: rtl/memory_arbiter_rr_picker.sv
// memory_arbiter_rr_picker: combinational round-robin pick; req[N] requests, ptr start index -> gnt_idx winner, any
module memory_arbiter_rr_picker #(
  parameter int N = 2,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any
);
  logic [W-1:0] j;
  logic         found;
  assign any = |req;
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    j       = ptr;
    for (int k = 0; k < N; k++) begin
      if (req[j] && !found) begin
        gnt_idx = j;
        found   = 1'b1;
      end
      j = (j == W'(N - 1)) ? '0 : j + 1'b1;
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: CPUS x (I,D) channels onto one RAM port; CLK, RST (async high), bus = slave side of memory_arbiter_if
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic             CLK,
  input logic             RST,
  memory_arbiter_if.slave bus
);
  localparam int PW = CPUS > 1 ? $clog2(CPUS) : 1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  arb_state_t        state, state_n;
  logic [PW-1:0]     owner, rr_ptr, d_idx, i_idx;
  logic              owner_is_d, op_wr, d_any, i_any;
  logic              alive, serving, done, tick;
  logic [TW-1:0]     tmo_cnt;
  logic [ADDR_W-1:0] ia [CPUS];
  logic [ADDR_W-1:0] da [CPUS];
  logic [WORD_W-1:0] ds [CPUS];
  memory_arbiter_rr_picker #(.N(CPUS)) d_pick (
    .req(bus.dREN | bus.dWEN), .ptr(rr_ptr), .gnt_idx(d_idx), .any(d_any)
  );
  memory_arbiter_rr_picker #(.N(CPUS)) i_pick (
    .req(bus.iREN), .ptr(rr_ptr), .gnt_idx(i_idx), .any(i_any)
  );
  // The owner must still present the exact op it was granted; a drop or a read/write flip aborts.
  assign alive   = owner_is_d ? (op_wr ? bus.dWEN[owner] : bus.dREN[owner] && !bus.dWEN[owner])
                              : bus.iREN[owner];
  assign serving = state == SERVE && alive;
  assign done    = serving && bus.ramstate == ACCESS;
  assign tick    = serving && bus.ramstate != ACCESS;
  assign bus.timeout_err = TIMEOUT > 0 && tick && tmo_cnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    if (state == IDLE && (d_any || i_any)) state_n = SERVE;
    if (state == SERVE && (done || !alive)) state_n = IDLE;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= '0;
      owner_is_d <= 1'b0;
      op_wr      <= 1'b0;
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        if (d_any || i_any) begin
          owner      <= d_any ? d_idx : i_idx;
          owner_is_d <= d_any;
          op_wr      <= d_any && bus.dWEN[d_idx];
        end
      end else if (done) begin
        rr_ptr  <= owner == PW'(CPUS - 1) ? '0 : owner + 1'b1;
        tmo_cnt <= '0;
      end else if (tick) begin
        tmo_cnt <= (bus.timeout_err || TIMEOUT == 0) ? '0 : tmo_cnt + 1'b1;
      end
    end
  end
  for (genvar g = 0; g < CPUS; g++) begin : g_lane
    assign ia[g] = bus.iaddr[g*ADDR_W +: ADDR_W];
    assign da[g] = bus.daddr[g*ADDR_W +: ADDR_W];
    assign ds[g] = bus.dstore[g*WORD_W +: WORD_W];
    assign bus.iwait[g] = !(done && !owner_is_d && owner == PW'(g));
    assign bus.dwait[g] = !(done && owner_is_d && owner == PW'(g));
    assign bus.iload[g*WORD_W +: WORD_W] = done && !owner_is_d && owner == PW'(g) ? bus.ramload : '0;
    assign bus.dload[g*WORD_W +: WORD_W] = done && owner_is_d && !op_wr && owner == PW'(g) ? bus.ramload : '0;
  end
  assign bus.ramaddr  = serving ? (owner_is_d ? da[owner] : ia[owner]) : '0;
  assign bus.ramstore = serving && op_wr ? ds[owner] : '0;
  assign bus.ramWEN   = serving && op_wr;
  assign bus.ramREN   = serving && !op_wr;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector table plus timeout and async-reset sequences for memory_arbiter
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;
  typedef struct {
    logic [1:0]   iren;
    logic [1:0]   dren;
    logic [1:0]   dwen;
    ramstate_t    rs;
    logic [31:0]  rl;
    logic [198:0] exp;
  } vec_t;
  localparam logic [198:0] DEF = {2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0, 1'b0};
  logic clk = 1'b0;
  logic rst;
  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;
  memory_arbiter_if #(.CPUS(2), .ADDR_W(32), .WORD_W(32)) bus ();
  memory_arbiter #(.CPUS(2), .ADDR_W(32), .WORD_W(32), .TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
  function automatic logic [198:0] o(logic [1:0] iw, logic [1:0] dw, logic ren, logic wen,
                                     logic [31:0] addr, logic [31:0] store,
                                     logic [63:0] il, logic [63:0] dl, logic te);
    return {iw, dw, ren, wen, addr, store, il, dl, te};
  endfunction
  function automatic void add(logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen,
                              ramstate_t rs, logic [31:0] rl, logic [198:0] e);
    vecs.push_back('{iren, dren, dwen, rs, rl, e});
  endfunction
  function automatic logic [198:0] obs();
    return {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore,
            bus.iload, bus.dload, bus.timeout_err};
  endfunction
  task automatic chk(string name, logic [198:0] act, logic [198:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen,
                       ramstate_t rs, logic [31:0] rl);
    bus.iREN = iren;
    bus.dREN = dren;
    bus.dWEN = dwen;
    bus.ramstate = rs;
    bus.ramload = rl;
  endtask
  initial begin
    bus.iaddr  = {32'h200, 32'h100};
    bus.daddr  = {32'h80, 32'h40};
    bus.dstore = {32'h5678, 32'h1234};
    drive(2'b00, 2'b11, 2'b00, FREE, 32'h0);
    rst = 1'b1;
    // CPU0 instruction fetch with two BUSY cycles
    add(2'b01, 2'b00, 2'b00, FREE,   32'h0,    DEF);
    add(2'b01, 2'b00, 2'b00, BUSY,   32'h0,    o(2'b11, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 64'h0, 64'h0, 1'b0));
    add(2'b01, 2'b00, 2'b00, BUSY,   32'h0,    o(2'b11, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 64'h0, 64'h0, 1'b0));
    add(2'b01, 2'b00, 2'b00, ACCESS, 32'hDEAD, o(2'b10, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 64'hDEAD, 64'h0, 1'b0));
    add(2'b00, 2'b00, 2'b00, FREE,   32'h0,    DEF);
    // CPU1 read aborted; rr_ptr stays at 1 so the next contested grant goes to CPU1
    add(2'b00, 2'b10, 2'b00, FREE,   32'h0,    DEF);
    add(2'b00, 2'b10, 2'b00, BUSY,   32'h0,    o(2'b11, 2'b11, 1'b1, 1'b0, 32'h80, 32'h0, 64'h0, 64'h0, 1'b0));
    add(2'b00, 2'b00, 2'b00, BUSY,   32'h0,    DEF);
    add(2'b00, 2'b11, 2'b00, FREE,   32'h0,    DEF);
    add(2'b00, 2'b11, 2'b00, ACCESS, 32'h5555, o(2'b11, 2'b01, 1'b1, 1'b0, 32'h80, 32'h0, 64'h0, {32'h5555, 32'h0}, 1'b0));
    // both CPUs hold dREN: grants 0,1,0,1
    for (int r = 0; r < 2; r++) begin
      add(2'b00, 2'b11, 2'b00, FREE,   32'h0,       DEF);
      add(2'b00, 2'b11, 2'b00, ACCESS, 32'h1111 + r, o(2'b11, 2'b10, 1'b1, 1'b0, 32'h40, 32'h0, 64'h0, {32'h0, 32'h1111 + r}, 1'b0));
      add(2'b00, 2'b11, 2'b00, FREE,   32'h0,       DEF);
      add(2'b00, 2'b11, 2'b00, ACCESS, 32'h2222 + r, o(2'b11, 2'b01, 1'b1, 1'b0, 32'h80, 32'h0, 64'h0, {32'h2222 + r, 32'h0}, 1'b0));
    end
    // CPU0 write beats CPU1 fetch; fetch follows after an IDLE cycle
    add(2'b10, 2'b00, 2'b01, FREE,   32'h0,    DEF);
    add(2'b10, 2'b00, 2'b01, BUSY,   32'h0,    o(2'b11, 2'b11, 1'b0, 1'b1, 32'h40, 32'h1234, 64'h0, 64'h0, 1'b0));
    add(2'b10, 2'b00, 2'b01, ACCESS, 32'hBEEF, o(2'b11, 2'b10, 1'b0, 1'b1, 32'h40, 32'h1234, 64'h0, 64'h0, 1'b0));
    add(2'b10, 2'b00, 2'b00, FREE,   32'h0,    DEF);
    add(2'b10, 2'b00, 2'b00, ACCESS, 32'hCAFE, o(2'b01, 2'b11, 1'b1, 1'b0, 32'h200, 32'h0, {32'hCAFE, 32'h0}, 64'h0, 1'b0));
    add(2'b00, 2'b00, 2'b00, FREE,   32'h0,    DEF);
    // read flips to write mid-transaction: abort, then regrant as write
    add(2'b00, 2'b01, 2'b00, FREE,   32'h0,    DEF);
    add(2'b00, 2'b01, 2'b01, BUSY,   32'h0,    DEF);
    add(2'b00, 2'b00, 2'b01, FREE,   32'h0,    DEF);
    add(2'b00, 2'b00, 2'b01, ACCESS, 32'h9999, o(2'b11, 2'b10, 1'b0, 1'b1, 32'h40, 32'h1234, 64'h0, 64'h0, 1'b0));
    add(2'b00, 2'b00, 2'b00, FREE,   32'h0,    DEF);
    // same CPU asks I and D: D first
    add(2'b01, 2'b01, 2'b00, FREE,   32'h0,    DEF);
    add(2'b01, 2'b01, 2'b00, ACCESS, 32'h7777, o(2'b11, 2'b10, 1'b1, 1'b0, 32'h40, 32'h0, 64'h0, 64'h7777, 1'b0));
    add(2'b01, 2'b00, 2'b00, FREE,   32'h0,    DEF);
    add(2'b01, 2'b00, 2'b00, ACCESS, 32'h8888, o(2'b10, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 64'h8888, 64'h0, 1'b0));
    add(2'b00, 2'b00, 2'b00, FREE,   32'h0,    DEF);
    #12;
    chk("reset", obs(), DEF);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, FREE, 32'h0);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].rs, vecs[i].rl);
      #1;
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    // timeout: BUSY forever, pulses on SERVE cycles 8 and 16, then ACCESS completes
    @(negedge clk);
    drive(2'b00, 2'b01, 2'b00, BUSY, 32'h0);
    #1;
    chk("tmo_idle", obs(), DEF);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("tmo_c%0d", k), {bus.timeout_err, bus.ramREN}, {(k == 8 || k == 16), 1'b1});
    end
    @(negedge clk);
    drive(2'b00, 2'b01, 2'b00, ACCESS, 32'hABCD);
    #1;
    chk("tmo_done", {bus.timeout_err, bus.dwait, bus.dload}, {1'b0, 2'b10, 64'hABCD});
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, FREE, 32'h0);
    // async reset in the middle of a CPU1 write, then CPU0 wins a contested grant
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b10, BUSY, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_pre", {bus.ramWEN, bus.ramaddr, bus.ramstore}, {1'b1, 32'h80, 32'h5678});
    #1 rst = 1'b1;
    #1;
    chk("rst_async", obs(), DEF);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 2'b11, 2'b00, FREE, 32'h0);
    #1;
    chk("rst_idle", obs(), DEF);
    @(negedge clk);
    #1;
    chk("rst_grant", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h40});
    drive(2'b00, 2'b00, 2'b00, FREE, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
